fractal_scan_engine: RTL and testbench
======================================

# fractal_scan_engine

Parametrised escape-time fractal engine: scans an X_SIZE × Y_SIZE frame in raster order and emits one iteration count per pixel on a valid/ready stream with start-of-frame and end-of-line markers. Supports Mandelbrot and Julia mode with a programmable Julia constant. Runs on the video stream clock, fed by the AXI-Lite register file, and drives the pixel packer/colour-map stage.

## Interface
- W, 32: signed fixed-point word width.
- F, 24: fraction bits (value = word / 2^F).
- IW, 8: iteration-count width.
- X_SIZE, 640: pixels per line.
- Y_SIZE, 480: lines per frame.
- aclk  in  1  sole clock.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- cont  in  1  high at frame end: immediately start the next frame.
- mode  in  1  0 = Mandelbrot, 1 = Julia.
- max_iter  in  IW  iteration limit.
- re_min, im_min  in  W  coordinate of pixel (0,0).
- re_step, im_step  in  W  per-pixel and per-line increments.
- jc_re, jc_im  in  W  Julia constant.
- busy  out  1  high from frame load until last beat accepted.
- m_iter  out  IW  iteration count.
- m_escaped  out  1  1 = escaped, 0 = hit limit.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tuser  out  1  beat is pixel (0,0).
- m_tlast  out  1  beat is x = X_SIZE-1.

## Operation
- States: IDLE, LOAD, INIT, ITER, OUT.
- IDLE: start=1 → LOAD. Start is ignored in every other state.
- LOAD (1 cycle): latch mode, max_iter, all coordinates, steps and the Julia constant. Set x=y=0, cr=re_min, ci=im_min. Go to INIT. Inputs that change mid-frame have no effect.
- INIT (1 cycle): n=0.
  - Mandelbrot: z=0, c=(cr,ci).
  - Julia: z=(cr,ci), c=(jc_re,jc_im).
  - Go to ITER.
- ITER, one check per cycle:
  - zr2 = (zr·zr)>>>F, zi2 = (zi·zi)>>>F, full 2W-bit product, arithmetic shift, kept at 2W-F bits.
  - If zr2+zi2 > 4·2^F (sum in 2W-F+1 bits, signed compare): m_iter=n, escaped=1 → OUT.
  - Else if n == max_iter: m_iter=max_iter, escaped=0 → OUT.
  - Else: zr = trunc_W(zr2-zi2)+c_re; zi = trunc_W((2·zr·zi)>>>F)+c_im; n++.
  - All W-bit adds wrap modulo 2^W.
- OUT: m_tvalid=1. On m_tvalid && m_tready, advance the scan:
  - x<X_SIZE-1: x++, cr += re_step → INIT.
  - Else x=0, cr=re_min latched.
    - y<Y_SIZE-1: y++, ci += im_step → INIT.
    - Else frame end: cont=1 → LOAD with a fresh config latch; cont=0 → IDLE.
- Sideband: m_tuser = (x==0 && y==0); m_tlast = (x==X_SIZE-1). Both are meaningful only while m_tvalid=1.
- busy = (state != IDLE).

## Timing
- Reset values: state IDLE, all outputs 0, x=y=n=0.
- Reset mid-frame: async abort to IDLE. m_tvalid drops immediately. The in-flight beat is lost and no partial frame resumes.
- Start to first INIT: 2 cycles (start sampled, LOAD).
- Per pixel, ready held high: k+3 cycles (INIT + k+1 ITER + 1 OUT), where k = m_iter.
- Stream protocol:
  - m_iter, m_escaped, m_tuser and m_tlast are held stable while m_tvalid=1 and m_tready=0.
  - m_tvalid never drops without a handshake, except on reset.
  - No combinational path from m_tready to m_tvalid.
- max_iter=0: one ITER cycle. Output is 0, with escaped set by the magnitude test.
- Magnitude exactly 4.0 does not escape (strict >).
- Back-to-back frames with cont=1: LOAD follows the last handshake on the next cycle.

## Structure
- Package fractal_pkg holds:
  - state enum;
  - mode constants (MODE_MANDEL=0, MODE_JULIA=1);
  - the escape threshold localparam;
  - a fixed-point multiply-shift function parameterised on W and F.
- Sub-module fractal_step: combinational datapath. Inputs z, c. Outputs zr2+zi2 escape flag and next z. Instanced once; the FSM, scan counters and coordinate accumulators stay in the top.

## Test plan
- Mandelbrot, X_SIZE=1, Y_SIZE=1, re_min=0, im_min=0, max_iter=20 → m_iter=20, m_escaped=0, m_tuser=m_tlast=1, busy falls after the handshake.
- Mandelbrot, c=2.0 (re_min=0x0200_0000), max_iter=20 → m_iter=2, m_escaped=1, 5 cycles from INIT entry to OUT exit with ready high.
- Julia, jc=0, re_min=3.0 (0x0300_0000), max_iter=10 → m_iter=0, m_escaped=1.
- X_SIZE=4, Y_SIZE=2, cont=0 → exactly 8 beats, m_tuser on beat 0 only, m_tlast on beats 3 and 7, then IDLE.
- m_tready toggled randomly with ~30% duty → beats identical to the ready-high run and stable while stalled; no beats lost or duplicated.
- areset pulsed on the 3rd beat of a frame → m_tvalid=0 and busy=0 immediately. A new start yields beat 0 with m_tuser=1.

Source files
------------

// File: rtl/fractal_pkg.sv
// fractal_pkg: shared types and helpers for the escape-time fractal engine.
//   state_t       - scan/iteration FSM states
//   MODE_*        - fractal mode select encodings
//   ESCAPE_MAG    - |z|^2 escape threshold in integer units (scaled by 2^F at use)
//   fx_mul_shift  - signed fixed-point multiply followed by arithmetic right shift
package fractal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_INIT = 3'd2,
        ST_ITER = 3'd3,
        ST_OUT  = 3'd4
    } state_t;

    localparam logic MODE_MANDEL = 1'b0;
    localparam logic MODE_JULIA  = 1'b1;

    localparam int unsigned ESCAPE_MAG = 32'd4;

    // Widest operand the multiply helper handles; callers sign-extend W-bit words to this.
    localparam int unsigned FX_MAX_W = 32'd64;

    // Full-precision signed product of two sign-extended words, shifted right
    // arithmetically by the fraction-bit count. Callers cast the result down to
    // the width they need, which makes the helper independent of W.
    function automatic logic signed [2*FX_MAX_W-1:0] fx_mul_shift(
        input logic signed [FX_MAX_W-1:0] a,
        input logic signed [FX_MAX_W-1:0] b,
        input int unsigned                shift
    );
        logic signed [2*FX_MAX_W-1:0] prod;
        // Low 2*FX_MAX_W bits of the product of the sign-extended operands equal
        // the two's-complement signed product.
        prod = {{FX_MAX_W{a[FX_MAX_W-1]}}, a} * {{FX_MAX_W{b[FX_MAX_W-1]}}, b};
        return prod >>> shift;
    endfunction

endpackage

// File: rtl/fractal_step.sv
// fractal_step: one combinational escape-time iteration.
//   zr, zi     in  current z (W-bit signed, F fraction bits)
//   cr, ci     in  constant c
//   escape     out |z|^2 > 4.0 (strict)
//   zr_next    out re(z^2 + c), wraps modulo 2^W
//   zi_next    out im(z^2 + c), wraps modulo 2^W
module fractal_step
    import fractal_pkg::*;
#(
    parameter int W = 32,
    parameter int F = 24
) (
    input  logic signed [W-1:0] zr,
    input  logic signed [W-1:0] zi,
    input  logic signed [W-1:0] cr,
    input  logic signed [W-1:0] ci,
    output logic                escape,
    output logic signed [W-1:0] zr_next,
    output logic signed [W-1:0] zi_next
);

    // Squares keep 2W-F bits so large magnitudes still compare correctly.
    localparam int PW = 2 * W - F;
    localparam logic signed [PW:0] ESC_THRESH = (PW + 1)'(ESCAPE_MAG) << F;

    logic signed [FX_MAX_W-1:0] zr_ext_s;
    logic signed [FX_MAX_W-1:0] zi_ext_s;
    logic signed [PW-1:0]       zr2_s;
    logic signed [PW-1:0]       zi2_s;
    logic signed [PW:0]         mag_s;
    logic signed [W-1:0]        diff_s;
    logic signed [W-1:0]        cross_s;

    assign zr_ext_s = {{(FX_MAX_W - W){zr[W-1]}}, zr};
    assign zi_ext_s = {{(FX_MAX_W - W){zi[W-1]}}, zi};

    assign zr2_s = PW'(fx_mul_shift(zr_ext_s, zr_ext_s, F));
    assign zi2_s = PW'(fx_mul_shift(zi_ext_s, zi_ext_s, F));

    // Sum widened by one bit so it can never wrap before the compare.
    assign mag_s  = {zr2_s[PW-1], zr2_s} + {zi2_s[PW-1], zi2_s};
    assign escape = (mag_s > ESC_THRESH);

    // (2*zr*zi)>>>F equals (zr*zi)>>>(F-1) exactly and avoids the doubling overflow.
    assign diff_s  = W'(zr2_s - zi2_s);
    assign cross_s = W'(fx_mul_shift(zr_ext_s, zi_ext_s, F - 1));

    assign zr_next = diff_s + cr;
    assign zi_next = cross_s + ci;

endmodule

// File: rtl/fractal_scan_engine.sv
// fractal_scan_engine: raster-scans an X_SIZE x Y_SIZE frame and emits one
// escape-time iteration count per pixel on a valid/ready stream.
//   aclk, areset            clock, asynchronous active-high reset
//   start, cont             frame start (IDLE only), auto-restart at frame end
//   mode, max_iter          Mandelbrot/Julia select, iteration limit
//   re_min, im_min          coordinate of pixel (0,0)
//   re_step, im_step        per-pixel / per-line increments
//   jc_re, jc_im            Julia constant
//   busy                    high whenever not IDLE
//   m_iter, m_escaped       beat payload
//   m_tvalid, m_tready      stream handshake
//   m_tuser, m_tlast        start-of-frame / end-of-line markers
module fractal_scan_engine
    import fractal_pkg::*;
#(
    parameter int W      = 32,
    parameter int F      = 24,
    parameter int IW     = 8,
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                start,
    input  logic                cont,
    input  logic                mode,
    input  logic [IW-1:0]       max_iter,
    input  logic signed [W-1:0] re_min,
    input  logic signed [W-1:0] im_min,
    input  logic signed [W-1:0] re_step,
    input  logic signed [W-1:0] im_step,
    input  logic signed [W-1:0] jc_re,
    input  logic signed [W-1:0] jc_im,
    output logic                busy,
    output logic [IW-1:0]       m_iter,
    output logic                m_escaped,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tuser,
    output logic                m_tlast
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    state_t state_q, state_d;

    // Latched frame configuration
    logic                mode_q, mode_d;
    logic [IW-1:0]       max_iter_q, max_iter_d;
    logic signed [W-1:0] re_min_q, re_min_d, im_min_q, im_min_d;
    logic signed [W-1:0] re_step_q, re_step_d, im_step_q, im_step_d;
    logic signed [W-1:0] jc_re_q, jc_re_d, jc_im_q, jc_im_d;

    // Scan position, coordinate accumulators and iteration state
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic signed [W-1:0] cr_q, cr_d, ci_q, ci_d;
    logic signed [W-1:0] zr_q, zr_d, zi_q, zi_d;
    logic signed [W-1:0] c_re_q, c_re_d, c_im_q, c_im_d;
    logic [IW-1:0]       n_q, n_d;

    // Registered outputs
    logic          busy_q, busy_d, m_tvalid_q, m_tvalid_d;
    logic [IW-1:0] m_iter_q, m_iter_d;
    logic          m_escaped_q, m_escaped_d, m_tuser_q, m_tuser_d, m_tlast_q, m_tlast_d;

    logic                escape_s, limit_s, beat_s, x_last_s, y_last_s;
    logic signed [W-1:0] zr_next_s, zi_next_s;

    fractal_step #(.W(W), .F(F)) u_step (
        .zr      (zr_q),
        .zi      (zi_q),
        .cr      (c_re_q),
        .ci      (c_im_q),
        .escape  (escape_s),
        .zr_next (zr_next_s),
        .zi_next (zi_next_s)
    );

    assign limit_s  = (n_q == max_iter_q);
    assign beat_s   = m_tvalid_q && m_tready;
    assign x_last_s = (x_q == X_LAST);
    assign y_last_s = (y_q == Y_LAST);

    assign busy      = busy_q;
    assign m_iter    = m_iter_q;
    assign m_escaped = m_escaped_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tuser   = m_tuser_q;
    assign m_tlast   = m_tlast_q;

    // FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD; else state_d = ST_IDLE;
            ST_LOAD: state_d = ST_INIT;
            ST_INIT: state_d = ST_ITER;
            ST_ITER: if (escape_s || limit_s) state_d = ST_OUT; else state_d = ST_ITER;
            ST_OUT: begin
                if (!beat_s) begin
                    state_d = ST_OUT;
                end else if (x_last_s && y_last_s) begin
                    state_d = cont ? ST_LOAD : ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values; outputs are registered so they decode state_d, not state_q.
    always_comb begin
        m_tvalid_d  = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        m_iter_d    = m_iter_q;
        m_escaped_d = m_escaped_q;
        m_tuser_d   = m_tuser_q;
        m_tlast_d   = m_tlast_q;
        // Payload is captured only on the ITER->OUT transition and held while stalled.
        if (state_q == ST_ITER && state_d == ST_OUT) begin
            m_iter_d    = escape_s ? n_q : max_iter_q;
            m_escaped_d = escape_s;
            m_tuser_d   = (x_q == {XW{1'b0}}) && (y_q == {YW{1'b0}});
            m_tlast_d   = x_last_s;
        end else begin
            m_iter_d    = m_iter_q;
            m_escaped_d = m_escaped_q;
        end
    end

    // Datapath next values: config latch, z iteration, scan advance
    always_comb begin
        mode_d = mode_q;       max_iter_d = max_iter_q;
        re_min_d = re_min_q;   im_min_d = im_min_q;
        re_step_d = re_step_q; im_step_d = im_step_q;
        jc_re_d = jc_re_q;     jc_im_d = jc_im_q;
        x_d = x_q;   y_d = y_q;   cr_d = cr_q;     ci_d = ci_q;
        zr_d = zr_q; zi_d = zi_q; c_re_d = c_re_q; c_im_d = c_im_q;
        n_d = n_q;
        case (state_q)
            ST_LOAD: begin
                mode_d = mode;       max_iter_d = max_iter;
                re_min_d = re_min;   im_min_d = im_min;
                re_step_d = re_step; im_step_d = im_step;
                jc_re_d = jc_re;     jc_im_d = jc_im;
                x_d = {XW{1'b0}};    y_d = {YW{1'b0}};
                cr_d = re_min;       ci_d = im_min;
            end
            ST_INIT: begin
                n_d = {IW{1'b0}};
                if (mode_q == MODE_JULIA) begin
                    zr_d = cr_q;    zi_d = ci_q;
                    c_re_d = jc_re_q; c_im_d = jc_im_q;
                end else begin
                    zr_d = {W{1'b0}}; zi_d = {W{1'b0}};
                    c_re_d = cr_q;    c_im_d = ci_q;
                end
            end
            ST_ITER: begin
                if (!escape_s && !limit_s) begin
                    zr_d = zr_next_s;
                    zi_d = zi_next_s;
                    n_d  = n_q + IW'(1);
                end else begin
                    n_d = n_q;
                end
            end
            ST_OUT: begin
                if (!beat_s) begin
                    x_d = x_q;
                end else if (!x_last_s) begin
                    x_d  = x_q + XW'(1);
                    cr_d = cr_q + re_step_q;
                end else begin
                    x_d  = {XW{1'b0}};
                    cr_d = re_min_q;
                    if (!y_last_s) begin
                        y_d  = y_q + YW'(1);
                        ci_d = ci_q + im_step_q;
                    end else begin
                        y_d  = {YW{1'b0}};
                        ci_d = im_min_q;
                    end
                end
            end
            default: n_d = n_q;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mode_d_reset: begin end
            mode_q <= 1'b0;            max_iter_q <= {IW{1'b0}};
            re_min_q <= {W{1'b0}};     im_min_q <= {W{1'b0}};
            re_step_q <= {W{1'b0}};    im_step_q <= {W{1'b0}};
            jc_re_q <= {W{1'b0}};      jc_im_q <= {W{1'b0}};
            x_q <= {XW{1'b0}};         y_q <= {YW{1'b0}};
            cr_q <= {W{1'b0}};         ci_q <= {W{1'b0}};
            zr_q <= {W{1'b0}};         zi_q <= {W{1'b0}};
            c_re_q <= {W{1'b0}};       c_im_q <= {W{1'b0}};
            n_q <= {IW{1'b0}};
            busy_q <= 1'b0;            m_tvalid_q <= 1'b0;
            m_iter_q <= {IW{1'b0}};    m_escaped_q <= 1'b0;
            m_tuser_q <= 1'b0;         m_tlast_q <= 1'b0;
        end else begin
            mode_q <= mode_d;          max_iter_q <= max_iter_d;
            re_min_q <= re_min_d;      im_min_q <= im_min_d;
            re_step_q <= re_step_d;    im_step_q <= im_step_d;
            jc_re_q <= jc_re_d;        jc_im_q <= jc_im_d;
            x_q <= x_d;                y_q <= y_d;
            cr_q <= cr_d;              ci_q <= ci_d;
            zr_q <= zr_d;              zi_q <= zi_d;
            c_re_q <= c_re_d;          c_im_q <= c_im_d;
            n_q <= n_d;
            busy_q <= busy_d;          m_tvalid_q <= m_tvalid_d;
            m_iter_q <= m_iter_d;      m_escaped_q <= m_escaped_d;
            m_tuser_q <= m_tuser_d;    m_tlast_q <= m_tlast_d;
        end
    end

endmodule

// File: tb/tb_fractal_scan_engine.sv
// tb_fractal_scan_engine: directed self-checking bench.
// u_dut_px is a 1x1 frame instance for single-pixel latency/value cases;
// u_dut is a 4x2 frame instance for scan order, backpressure, cont and reset.
module tb_fractal_scan_engine;

    localparam int W  = 32;
    localparam int F  = 24;
    localparam int IW = 8;

    logic                aclk = 1'b0;
    logic                areset = 1'b1;
    logic                start = 1'b0;
    logic                start_px = 1'b0;
    logic                cont = 1'b0;
    logic                mode = 1'b0;
    logic [IW-1:0]       max_iter = 8'd0;
    logic signed [W-1:0] re_min = 32'd0, im_min = 32'd0;
    logic signed [W-1:0] re_step = 32'd0, im_step = 32'd0;
    logic signed [W-1:0] jc_re = 32'd0, jc_im = 32'd0;
    logic                m_tready = 1'b1;

    logic          busy, m_escaped, m_tvalid, m_tuser, m_tlast;
    logic [IW-1:0] m_iter;
    logic          px_busy, px_escaped, px_tvalid, px_tuser, px_tlast;
    logic [IW-1:0] px_iter;

    int tests_run = 0;
    int tests_failed = 0;

    // Captured beats
    logic [IW-1:0] b_iter [16];
    logic          b_esc  [16];
    logic          b_user [16];
    logic          b_last [16];

    // Hand-computed 4x2 Julia frame (c=0, z0 = x + i*y, max_iter=3)
    logic [IW-1:0] exp_iter [8] = '{8'd3, 8'd3, 8'd1, 8'd0, 8'd3, 8'd2, 8'd0, 8'd0};
    logic [7:0]    exp_esc  = 8'b1110_1100;
    logic [7:0]    exp_user = 8'b0000_0001;
    logic [7:0]    exp_last = 8'b1000_1000;

    fractal_scan_engine #(.W(W), .F(F), .IW(IW), .X_SIZE(4), .Y_SIZE(2)) u_dut (
        .aclk(aclk), .areset(areset), .start(start), .cont(cont), .mode(mode),
        .max_iter(max_iter), .re_min(re_min), .im_min(im_min),
        .re_step(re_step), .im_step(im_step), .jc_re(jc_re), .jc_im(jc_im),
        .busy(busy), .m_iter(m_iter), .m_escaped(m_escaped), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tuser(m_tuser), .m_tlast(m_tlast)
    );

    fractal_scan_engine #(.W(W), .F(F), .IW(IW), .X_SIZE(1), .Y_SIZE(1)) u_dut_px (
        .aclk(aclk), .areset(areset), .start(start_px), .cont(cont), .mode(mode),
        .max_iter(max_iter), .re_min(re_min), .im_min(im_min),
        .re_step(re_step), .im_step(im_step), .jc_re(jc_re), .jc_im(jc_im),
        .busy(px_busy), .m_iter(px_iter), .m_escaped(px_escaped), .m_tvalid(px_tvalid),
        .m_tready(m_tready), .m_tuser(px_tuser), .m_tlast(px_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise one start line for a single cycle; returns at the negedge after it was sampled.
    task automatic pulse_start(input bit px);
        @(negedge aclk);
        if (px) start_px = 1'b1; else start = 1'b1;
        @(negedge aclk);
        start_px = 1'b0;
        start    = 1'b0;
    endtask

    // Single-pixel frame on the 1x1 instance: latency, payload, markers, busy release.
    task automatic run_px(input string tag, input int exp_lat, input int exp_it, input bit exp_e);
        int lat = 1;
        m_tready = 1'b1;
        pulse_start(1'b1);
        while (!px_tvalid && lat < 200) begin
            @(negedge aclk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_iter"}, 64'(px_iter), 64'(exp_it));
        check_eq({tag, "_escaped"}, 64'(px_escaped), 64'(exp_e));
        check_eq({tag, "_tuser"}, 64'(px_tuser), 64'd1);
        check_eq({tag, "_tlast"}, 64'(px_tlast), 64'd1);
        check_eq({tag, "_busy"}, 64'(px_busy), 64'd1);
        @(negedge aclk);
        check_eq({tag, "_busy_after"}, 64'(px_busy), 64'd0);
        check_eq({tag, "_valid_after"}, 64'(px_tvalid), 64'd0);
    endtask

    // Collect beats from u_dut; with rnd, ready is ~30% and stalled payload must hold.
    task automatic collect(input int nbeats, input bit rnd);
        int got = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [IW-1:0] h_iter = 8'd0;
        logic h_esc = 1'b0, h_user = 1'b0, h_last = 1'b0;
        while (got < nbeats && cyc < 3000) begin
            @(negedge aclk);
            cyc++;
            if (held) begin
                check_eq("stall_valid", 64'(m_tvalid), 64'd1);
                check_eq("stall_iter", 64'(m_iter), 64'(h_iter));
                check_eq("stall_esc", 64'(m_escaped), 64'(h_esc));
                check_eq("stall_user", 64'(m_tuser), 64'(h_user));
                check_eq("stall_last", 64'(m_tlast), 64'(h_last));
            end
            if (rnd) m_tready = ($urandom_range(0, 99) < 30);
            else     m_tready = 1'b1;
            if (m_tvalid && m_tready) begin
                b_iter[got] = m_iter;
                b_esc[got]  = m_escaped;
                b_user[got] = m_tuser;
                b_last[got] = m_tlast;
                got++;
                held = 1'b0;
            end else if (m_tvalid) begin
                held = 1'b1;
                h_iter = m_iter; h_esc = m_escaped; h_user = m_tuser; h_last = m_tlast;
            end else begin
                held = 1'b0;
            end
        end
        check_eq("beat_count", 64'(got), 64'(nbeats));
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s_iter%0d", tag, i), 64'(b_iter[i]), 64'(exp_iter[i]));
            check_eq($sformatf("%s_esc%0d", tag, i), 64'(b_esc[i]), 64'(exp_esc[i]));
            check_eq($sformatf("%s_user%0d", tag, i), 64'(b_user[i]), 64'(exp_user[i]));
            check_eq($sformatf("%s_last%0d", tag, i), 64'(b_last[i]), 64'(exp_last[i]));
        end
    endtask

    task automatic frame_config();
        mode = 1'b1; max_iter = 8'd3;
        re_min = 32'd0; im_min = 32'd0;
        re_step = 32'h0100_0000; im_step = 32'h0100_0000;
        jc_re = 32'd0; jc_im = 32'd0;
    endtask

    initial begin
        int wait_cyc;

        // Reset state
        repeat (3) @(negedge aclk);
        check_eq("rst_valid", 64'(m_tvalid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_iter", 64'(m_iter), 64'd0);
        check_eq("rst_escaped", 64'(m_escaped), 64'd0);
        check_eq("rst_tuser", 64'(m_tuser), 64'd0);
        check_eq("rst_tlast", 64'(m_tlast), 64'd0);
        areset = 1'b0;

        // Single-pixel cases: latency is k+4 negedges after the start pulse
        mode = 1'b0; re_min = 32'd0; im_min = 32'd0; max_iter = 8'd20;
        run_px("mandel_limit", 24, 20, 1'b0);
        re_min = 32'h0200_0000;
        run_px("mandel_c2", 6, 2, 1'b1);
        mode = 1'b1; re_min = 32'h0300_0000; max_iter = 8'd10;
        run_px("julia_r3", 4, 0, 1'b1);
        mode = 1'b0; re_min = 32'd0; max_iter = 8'd0;
        run_px("maxiter0", 4, 0, 1'b0);

        // 4x2 frame, ready held high
        frame_config();
        pulse_start(1'b0);
        collect(8, 1'b0);
        check_frame("ready_high");
        @(negedge aclk);
        check_eq("frame_end_busy", 64'(busy), 64'd0);
        check_eq("frame_end_valid", 64'(m_tvalid), 64'd0);

        // Same frame with random backpressure; config scrambled after LOAD must not matter
        pulse_start(1'b0);
        @(negedge aclk);
        mode = 1'b0; re_min = 32'h0500_0000; max_iter = 8'd1; re_step = 32'd0;
        collect(8, 1'b1);
        check_frame("backpressure");
        @(negedge aclk);
        check_eq("bp_end_busy", 64'(busy), 64'd0);
        frame_config();

        // Back-to-back frames with cont
        cont = 1'b1;
        pulse_start(1'b0);
        collect(8, 1'b0);
        @(negedge aclk);
        check_eq("cont_busy_held", 64'(busy), 64'd1);
        check_eq("cont_gap_valid", 64'(m_tvalid), 64'd0);
        cont = 1'b0;
        collect(8, 1'b0);
        check_frame("cont_frame2");
        @(negedge aclk);
        check_eq("cont_end_busy", 64'(busy), 64'd0);

        // Async reset while the third beat is pending
        pulse_start(1'b0);
        collect(2, 1'b0);
        @(negedge aclk);
        m_tready = 1'b0;
        wait_cyc = 0;
        while (!m_tvalid && wait_cyc < 200) begin
            @(negedge aclk);
            wait_cyc++;
        end
        check_eq("rst_third_valid", 64'(m_tvalid), 64'd1);
        #2 areset = 1'b1;
        #1;
        check_eq("rst_mid_valid", 64'(m_tvalid), 64'd0);
        check_eq("rst_mid_busy", 64'(busy), 64'd0);
        @(negedge aclk);
        areset = 1'b0;
        m_tready = 1'b1;
        @(negedge aclk);
        check_eq("rst_no_resume", 64'(busy), 64'd0);
        pulse_start(1'b0);
        collect(1, 1'b0);
        check_eq("rst_restart_user", 64'(b_user[0]), 64'd1);
        check_eq("rst_restart_iter", 64'(b_iter[0]), 64'd3);
        check_eq("rst_restart_last", 64'(b_last[0]), 64'd0);

        repeat (3) @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
